// File: rtl/qupls_icache_filler.sv
// qupls_icache_filler -- instruction-cache line filler.
//
// On an instruction-cache miss, this block fetches one 64-byte line as four
// 128-bit bus beats. It assembles the beats into one line and writes the line
// into a round-robin selected way.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   ihit, miss_vadr,         miss detection (32'hFFFD0000 = no miss),
//   miss_asid                ASID of the missing fetch
//   flush                    abandon any fill in progress
//   req_v/req_rdy            bus request handshake
//   req_adr/req_asid/req_tid beat address, ASID, tag {seq,beat}
//   resp_v/resp_err          response beat valid, bus error
//   resp_tid/resp_adr/       response tag, physical address, beat data
//   resp_dat
//   ic_line_o                assembled line (vtag, ptag, per-beat valid, data)
//   wway/wr_ic               target way, one-cycle write strobe
//   busy/err                 fill in progress, one-cycle error pulse

package qupls_icache_filler_pkg;
    typedef struct packed {
        logic [31:0]  vtag;
        logic [31:0]  ptag;
        logic [3:0]   v;
        logic [511:0] data;
    } ICacheLine;
endpackage

module qupls_icache_filler
    import qupls_icache_filler_pkg::*;
#(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned LOBIT = 7,
    parameter int unsigned TMO   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ihit,
    input  logic [31:0]           miss_vadr,
    input  logic [15:0]           miss_asid,
    input  logic                  flush,
    output logic                  req_v,
    input  logic                  req_rdy,
    output logic [31:0]           req_adr,
    output logic [15:0]           req_asid,
    output logic [3:0]            req_tid,
    input  logic                  resp_v,
    input  logic                  resp_err,
    input  logic [3:0]            resp_tid,
    input  logic [31:0]           resp_adr,
    input  logic [127:0]          resp_dat,
    output ICacheLine             ic_line_o,
    output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] wway,
    output logic                  wr_ic,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TW  = $clog2(TMO + 1);
    // LOBIT is the line-select bit; the bits below it, minus one, are the byte offset within a 64-byte line.
    localparam int unsigned OFS = LOBIT - 1;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFS) - 32'd1);
    localparam logic [31:0] NO_MISS   = 32'hFFFD0000;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, HOLD} state_t;

    state_t        state;
    logic [1:0]    seq;
    logic [1:0]    beat;
    logic [3:0]    mask;
    logic [TW-1:0] timer;
    logic [WW-1:0] rr;
    logic [15:0]   asid;
    logic          hold;

    logic          resp_ok;
    logic [1:0]    rbeat;
    logic [3:0]    mask_nx;
    logic          req_done;
    logic          tmo_hit;

    // The latched miss address sits in vtag for the whole fill.
    assign req_adr  = ic_line_o.vtag + {26'd0, beat, 4'd0};
    assign req_asid = asid;
    assign req_tid  = {seq, beat};
    assign busy     = (state != IDLE);

    assign rbeat    = resp_tid[1:0];
    assign resp_ok  = resp_v && (resp_tid[3:2] == seq) && (state == REQ || state == WAIT);
    assign mask_nx  = mask | (resp_ok ? (4'b0001 << rbeat) : 4'b0000);
    assign req_done = (state == REQ) && req_v && req_rdy && (beat == 2'd3);
    assign tmo_hit  = (timer == TW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            seq       <= '0;
            beat      <= '0;
            mask      <= '0;
            timer     <= '0;
            rr        <= '0;
            asid      <= '0;
            hold      <= 1'b0;
            req_v     <= 1'b0;
            wr_ic     <= 1'b0;
            err       <= 1'b0;
            wway      <= '0;
            ic_line_o <= '0;
        end else begin
            wr_ic <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        seq <= seq + 2'd1;
                    end else if (!ihit && miss_vadr != NO_MISS) begin
                        ic_line_o.vtag <= miss_vadr & LINE_MASK;
                        ic_line_o.v    <= '0;
                        asid           <= miss_asid;
                        mask           <= '0;
                        beat           <= '0;
                        timer          <= TW'(TMO);
                        req_v          <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ, WAIT: begin
                    // Flush and timeout win over any response that arrives in the same cycle.
                    if (flush || tmo_hit) begin
                        err   <= tmo_hit && !flush;
                        seq   <= seq + 2'd1;
                        req_v <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                        if (resp_ok) begin
                            ic_line_o.data[{rbeat, 7'd0} +: 128] <= resp_dat;
                            ic_line_o.v[rbeat] <= !resp_err;
                            if (rbeat == 2'd0)
                                ic_line_o.ptag <= resp_adr & LINE_MASK;
                            err  <= resp_err;
                            mask <= mask_nx;
                        end
                        if (req_v && req_rdy) begin
                            beat <= beat + 2'd1;
                            if (beat == 2'd3)
                                req_v <= 1'b0;
                        end
                        if (mask_nx == 4'hF) begin
                            req_v <= 1'b0;
                            wr_ic <= 1'b1;
                            wway  <= rr;
                            state <= WRITE;
                        end else if (req_done) begin
                            state <= WAIT;
                        end
                    end
                end
                WRITE: begin
                    rr <= (rr == WW'(WAYS - 1)) ? '0 : rr + WW'(1);
                    if (flush) begin
                        seq   <= seq + 2'd1;
                        state <= IDLE;
                    end else begin
                        hold  <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // Two cycles for the tag array to see the new line before a new miss is taken.
                    if (flush) begin
                        seq   <= seq + 2'd1;
                        state <= IDLE;
                    end else if (!hold) begin
                        state <= IDLE;
                    end else begin
                        hold <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qupls_icache_filler.sv
// tb_qupls_icache_filler -- scoreboard bench for qupls_icache_filler.
// Stimulus tasks queue the expected bus requests, line writes and error
// pulses. A negedge monitor pops and compares them whenever the DUT shows
// one of these events.
module tb_qupls_icache_filler;
    import qupls_icache_filler_pkg::*;

    localparam int unsigned TMO = 255;
    localparam logic [31:0] NO_MISS = 32'hFFFD0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ihit;
    logic [31:0] miss_vadr;
    logic [15:0] miss_asid;
    logic        flush;
    logic        req_v;
    logic        req_rdy;
    logic [31:0] req_adr;
    logic [15:0] req_asid;
    logic [3:0]  req_tid;
    logic        resp_v;
    logic        resp_err;
    logic [3:0]  resp_tid;
    logic [31:0] resp_adr;
    logic [127:0] resp_dat;
    ICacheLine   ic_line_o;
    logic [1:0]  wway;
    logic        wr_ic;
    logic        busy;
    logic        err;

    qupls_icache_filler #(.WAYS(4), .LOBIT(7), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .ihit(ihit), .miss_vadr(miss_vadr), .miss_asid(miss_asid),
        .flush(flush), .req_v(req_v), .req_rdy(req_rdy), .req_adr(req_adr),
        .req_asid(req_asid), .req_tid(req_tid), .resp_v(resp_v), .resp_err(resp_err),
        .resp_tid(resp_tid), .resp_adr(resp_adr), .resp_dat(resp_dat),
        .ic_line_o(ic_line_o), .wway(wway), .wr_ic(wr_ic), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  tid;
        logic [15:0] asid;
    } req_t;

    typedef struct {
        logic [31:0]  vtag;
        logic [31:0]  ptag;
        logic [3:0]   v;
        logic [511:0] data;
        logic [1:0]   way;
    } wr_t;

    req_t exp_req[$];
    wr_t  exp_wr[$];
    int   exp_err[$];

    int   n_vec = 0;
    int   n_bad = 0;
    int   req_seen = 0;
    logic [1:0] seq_m = 2'd0;
    int   rr_m = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_adr;
    logic [3:0]  prev_tid;

    function automatic void check(input string name, input logic [575:0] act, input logic [575:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got event with value %0h expected none", name, act);
    endfunction

    function automatic logic [127:0] mkd(input int f, input int b);
        logic [7:0] x;
        x = 8'(f * 16 + b);
        return {16{x}};
    endfunction

    // Monitor: compare every DUT event against the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) begin
                check("stable_req_adr", req_adr, prev_adr);
                check("stable_req_tid", req_tid, prev_tid);
            end
            prev_stall = req_v && !req_rdy;
            prev_adr   = req_adr;
            prev_tid   = req_tid;
            if (req_v && req_rdy) begin
                if (exp_req.size() == 0) begin
                    unexpected("unexpected_req", req_adr);
                end else begin
                    req_t r;
                    r = exp_req.pop_front();
                    check("req_adr", req_adr, r.adr);
                    check("req_tid", req_tid, r.tid);
                    check("req_asid", req_asid, r.asid);
                end
                req_seen++;
            end
            if (wr_ic) begin
                if (exp_wr.size() == 0) begin
                    unexpected("unexpected_wr_ic", ic_line_o.vtag);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_vtag", ic_line_o.vtag, w.vtag);
                    check("wr_ptag", ic_line_o.ptag, w.ptag);
                    check("wr_v", ic_line_o.v, w.v);
                    check("wr_data", ic_line_o.data, w.data);
                    check("wr_way", wway, w.way);
                end
            end
            if (err) begin
                if (exp_err.size() == 0)
                    unexpected("unexpected_err", 32'(req_tid));
                else
                    void'(exp_err.pop_front());
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_reqs(input logic [31:0] va, input logic [15:0] as);
        for (int b = 0; b < 4; b++) begin
            req_t r;
            r.adr  = va + 32'(16 * b);
            r.tid  = {seq_m, 2'(b)};
            r.asid = as;
            exp_req.push_back(r);
        end
    endtask

    task automatic start_miss(input logic [31:0] mv, input logic [15:0] as);
        miss_vadr = mv;
        miss_asid = as;
        ihit = 1'b0;
        @(posedge clk); #1;
        ihit = 1'b1;
        miss_vadr = NO_MISS;
        check("busy_on_miss", busy, 1'b1);
    endtask

    task automatic wait_reqs(input int target, input logic [7:0] pat);
        int cnt = 0;
        while (req_seen < target && cnt < 60) begin
            req_rdy = pat[cnt % 8];
            @(posedge clk); #1;
            cnt++;
        end
        req_rdy = 1'b1;
        check("reqs_accepted", req_seen, target);
    endtask

    task automatic send_resp(input logic [3:0] tid, input logic [31:0] adr, input logic [127:0] d, input logic e);
        resp_v = 1'b1;
        resp_tid = tid;
        resp_adr = adr;
        resp_dat = d;
        resp_err = e;
        @(posedge clk); #1;
        resp_v = 1'b0;
        resp_err = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (busy && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("idle_after_fill", busy, 1'b0);
    endtask

    // One complete fill. order packs the response beat sequence as 2-bit slots (slot 0 first).
    task automatic full_fill(input int f, input logic [31:0] mv, input logic [15:0] as,
                             input logic [7:0] order, input logic [3:0] errs,
                             input logic [7:0] pat, input bit dup, input bit stale);
        wr_t e;
        logic [31:0] va, pb;
        logic [1:0] b;
        int target;
        va = mv & 32'hFFFF_FFC0;
        pb = 32'hA000_0040 + 32'(f) * 32'h1000;
        e.vtag = va;
        e.ptag = pb;
        e.v    = ~errs;
        e.way  = 2'(rr_m);
        for (int i = 0; i < 4; i++)
            e.data[128*i +: 128] = mkd(f, i);
        for (int i = 0; i < 4; i++)
            if (errs[i]) exp_err.push_back(f);
        exp_wr.push_back(e);
        target = req_seen + 4;
        push_reqs(va, as);
        start_miss(mv, as);
        wait_reqs(target, pat);
        if (stale)
            send_resp({seq_m - 2'd1, 2'd3}, pb, mkd(15, 15), 1'b1);
        if (dup)
            send_resp({seq_m, 2'd1}, pb + 32'h10, mkd(f, 9), 1'b0);
        for (int i = 0; i < 4; i++) begin
            b = order[2*i +: 2];
            send_resp({seq_m, b}, (b == 2'd0) ? (pb | 32'h5) : (pb + {26'd0, b, 4'd0}), mkd(f, b), errs[b]);
        end
        wait_idle();
        check("wr_consumed", exp_wr.size(), 0);
        rr_m = (rr_m + 1) % 4;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of run expected $finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int target;
        rst = 1'b1; ihit = 1'b1; miss_vadr = NO_MISS; miss_asid = '0; flush = 1'b0;
        req_rdy = 1'b1; resp_v = 1'b0; resp_err = 1'b0; resp_tid = '0; resp_adr = '0; resp_dat = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_req_v", req_v, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_ic", wr_ic, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_wway", wway, 2'd0);
        check("rst_line", ic_line_o, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // V-1: in-order beats, always ready
        full_fill(1, 32'h0000_1040, 16'h0011, 8'hE4, 4'b0000, 8'hFF, 1'b0, 1'b0);
        // V-2: out-of-order beats 3,1,0,2, toggling ready, duplicate beat 1, unaligned miss address
        full_fill(2, 32'h0000_2087, 16'h0022, 8'h87, 4'b0000, 8'b0110_1010, 1'b1, 1'b0);
        // V-3: bus error on beat 2
        full_fill(3, 32'h0000_3000, 16'h0033, 8'hE4, 4'b0100, 8'hFF, 1'b0, 1'b0);

        // V-4: no responses -> timeout after TMO cycles
        exp_err.push_back(4);
        push_reqs(32'h0000_4000, 16'h0044);
        start_miss(32'h0000_4000, 16'h0044);
        cnt = 0;
        while (busy && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("timeout_cycles", cnt, TMO);
        check("timeout_req_v", req_v, 1'b0);
        seq_m = seq_m + 2'd1;
        send_resp(4'b0000, 32'hA000_4040, mkd(4, 0), 1'b1);
        check("late_resp_idle", busy, 1'b0);
        check("err_consumed", exp_err.size(), 0);

        // V-5: flush in WAIT after two beats
        target = req_seen + 4;
        push_reqs(32'h0000_5000, 16'h0055);
        start_miss(32'h0000_5000, 16'h0055);
        wait_reqs(target, 8'hFF);
        send_resp({seq_m, 2'd0}, 32'hA000_5040, mkd(5, 0), 1'b0);
        send_resp({seq_m, 2'd1}, 32'hA000_5050, mkd(5, 1), 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", busy, 1'b0);
        check("flush_req_v", req_v, 1'b0);
        send_resp({seq_m, 2'd2}, 32'hA000_5060, mkd(5, 2), 1'b1);
        send_resp({seq_m, 2'd3}, 32'hA000_5070, mkd(5, 3), 1'b1);
        seq_m = seq_m + 2'd1;
        full_fill(6, 32'h0000_6000, 16'h0066, 8'h1B, 4'b0000, 8'hFF, 1'b0, 1'b1);
        // Fifth write wraps round-robin back to way 0
        full_fill(7, 32'h0000_7000, 16'h0077, 8'hE4, 4'b0000, 8'hFF, 1'b0, 1'b0);

        // V-6: no-miss address with ihit low stays idle
        ihit = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("nomiss_busy", busy, 1'b0);
        check("nomiss_req_v", req_v, 1'b0);
        ihit = 1'b1;

        // Reset asserted mid-REQ
        req_rdy = 1'b0;
        start_miss(32'h0000_9000, 16'h0099);
        check("req_v_in_req", req_v, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midrst_req_v", req_v, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_wr_ic", wr_ic, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_wway", wway, 2'd0);
        check("midrst_line", ic_line_o, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        req_rdy = 1'b1;
        seq_m = 2'd0;
        rr_m = 0;
        full_fill(8, 32'h0000_8000, 16'h0088, 8'hE4, 4'b0000, 8'hFF, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("req_queue_empty", exp_req.size(), 0);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("err_queue_empty", exp_err.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
